// File: rtl/imm_gen_stage_pkg.sv
// Shared types and constants for the immediate-generation stage and its decoder.
package imm_gen_stage_pkg;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_RSV   = 3'b111
  } imm_fmt_e;

  // Occupancy of the output/skid register pair.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and extension; shared by any stage that
// needs RISC-V style immediates.
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  if (XLEN != XLEN_32 && XLEN != XLEN_64) begin : g_xlen_check
    $error("imm_decode: XLEN must be 32 or 64");
  end

  // The opcode field carries no immediate bits.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  logic [31:0] raw;
  logic        sext;

  // Assemble a 32-bit immediate, then widen to XLEN with sign or zero fill.
  always_comb begin
    raw     = '0;
    sext    = 1'b1;
    illegal = 1'b0;
    case (imm_src)
      IMM_I: raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: raw = {instr[31:12], 12'b0};
      IMM_SHAMT: begin
        sext = 1'b0;
        if (XLEN == XLEN_64) begin
          raw = {26'b0, instr[25:20]};
        end else begin
          // A 6th shamt bit cannot address a 32-bit operand.
          raw     = {27'b0, instr[24:20]};
          illegal = instr[25];
        end
      end
      IMM_ZIMM: begin
        sext = 1'b0;
        raw  = {27'b0, instr[19:15]};
      end
      default: begin
        sext    = 1'b0;
        raw     = '0;
        illegal = 1'b1;
      end
    endcase
    imm = sext ? XLEN'($signed(raw)) : XLEN'(raw);
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decode on the input side, then an
// output register backed by one skid register so in_ready can be a flop.
//
//   state     | meaning
//   OCC_EMPTY | nothing held, out_valid=0
//   OCC_ONE   | output register holds an entry, skid empty
//   OCC_TWO   | output and skid both hold entries, in_ready=0
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .instr   (in_instr),
    .imm_src (imm_fmt_e'(in_imm_src)),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  occ_e             occ_q, occ_d;
  logic             in_ready_q, in_ready_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic             out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
  logic             accept, drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = (occ_q != OCC_EMPTY) && out_ready;

  // Next occupancy and register contents; flush overrides accept and drain.
  always_comb begin
    occ_d      = occ_q;
    out_imm_d  = out_imm_q;
    out_tag_d  = out_tag_q;
    out_ill_d  = out_ill_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    skid_ill_d = skid_ill_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            occ_d     = OCC_ONE;
            out_imm_d = dec_imm;
            out_tag_d = in_tag;
            out_ill_d = dec_illegal;
          end
        end
        OCC_ONE: begin
          if (accept && drain) begin
            out_imm_d = dec_imm;
            out_tag_d = in_tag;
            out_ill_d = dec_illegal;
          end else if (drain) begin
            occ_d = OCC_EMPTY;
          end else if (accept) begin
            occ_d      = OCC_TWO;
            skid_imm_d = dec_imm;
            skid_tag_d = in_tag;
            skid_ill_d = dec_illegal;
          end
        end
        OCC_TWO: begin
          // in_ready is low here, so only a drain can change anything.
          if (drain) begin
            occ_d     = OCC_ONE;
            out_imm_d = skid_imm_q;
            out_tag_d = skid_tag_q;
            out_ill_d = skid_ill_q;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
    in_ready_d = (occ_d != OCC_TWO);
  end

  // State and data registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      out_ill_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      out_imm_q  <= out_imm_d;
      out_tag_q  <= out_tag_d;
      out_ill_q  <= out_ill_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (occ_q != OCC_EMPTY);
  assign out_imm     = out_imm_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one stimulus
// stream; a per-instance queue of expected results is filled on acceptance
// and drained on output transfer.
module tb_imm_gen_stage;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_instr = '0;
  logic [2:0]       in_imm_src = '0;
  logic [TAG_W-1:0] in_tag = '0;

  logic             in_ready32, out_valid32, out_ill32;
  logic [31:0]      out_imm32;
  logic [TAG_W-1:0] out_tag32;
  logic             in_ready64, out_valid64, out_ill64;
  logic [63:0]      out_imm64;
  logic [TAG_W-1:0] out_tag64;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [63:0]      imm;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;

  imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_ill32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_ill64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: place the field at the top of a 64-bit word and shift it back
  // arithmetically to get sign extension.
  function automatic exp_t model(input logic [31:0] ins, input logic [2:0] src,
                                 input logic [TAG_W-1:0] tag, input bit is64);
    exp_t e;
    logic signed [63:0] s;
    e.tag = tag;
    e.ill = 1'b0;
    e.imm = '0;
    case (src)
      3'd0: begin s = $signed({ins[31:20], 52'b0}); e.imm = s >>> 52; end
      3'd1: begin s = $signed({ins[31:25], ins[11:7], 52'b0}); e.imm = s >>> 52; end
      3'd2: begin s = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 51'b0}); e.imm = s >>> 51; end
      3'd3: begin s = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 43'b0}); e.imm = s >>> 43; end
      3'd4: begin s = $signed({ins[31:12], 44'b0}); e.imm = s >>> 32; end
      3'd5: begin
        if (is64) e.imm = 64'(ins[25:20]);
        else begin e.imm = 64'(ins[24:20]); e.ill = ins[25]; end
      end
      3'd6: e.imm = 64'(ins[19:15]);
      default: begin e.imm = '0; e.ill = 1'b1; end
    endcase
    if (!is64) e.imm = {32'b0, e.imm[31:0]};
    return e;
  endfunction

  // Scoreboard: compare on transfer, enqueue on acceptance, clear on flush/reset.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      q32.delete();
      q64.delete();
    end else begin
      if (out_valid32 && out_ready) begin
        chk("sb32_occ", 64'(q32.size() != 0), 64'd1);
        if (q32.size() != 0) begin
          e32 = q32.pop_front();
          chk("sb32_imm", {32'b0, out_imm32}, e32.imm);
          chk("sb32_tag", 64'(out_tag32), 64'(e32.tag));
          chk("sb32_ill", 64'(out_ill32), 64'(e32.ill));
        end
      end
      if (out_valid64 && out_ready) begin
        chk("sb64_occ", 64'(q64.size() != 0), 64'd1);
        if (q64.size() != 0) begin
          e64 = q64.pop_front();
          chk("sb64_imm", out_imm64, e64.imm);
          chk("sb64_tag", 64'(out_tag64), 64'(e64.tag));
          chk("sb64_ill", 64'(out_ill64), 64'(e64.ill));
        end
      end
      if (in_valid && in_ready32) q32.push_back(model(in_instr, in_imm_src, in_tag, 1'b0));
      if (in_valid && in_ready64) q64.push_back(model(in_instr, in_imm_src, in_tag, 1'b1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one entry and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [TAG_W-1:0] tag);
    int budget;
    budget = 200;
    in_valid = 1'b1;
    in_instr = ins;
    in_imm_src = src;
    in_tag = tag;
    while (!in_ready32 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) chk("accept_timeout", 64'(in_ready32), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ov32"}, 64'(out_valid32), 64'd0);
    chk({tag, "_ir32"}, 64'(in_ready32), 64'd1);
    chk({tag, "_imm32"}, 64'(out_imm32), 64'd0);
    chk({tag, "_tag32"}, 64'(out_tag32), 64'd0);
    chk({tag, "_ill32"}, 64'(out_ill32), 64'd0);
    chk({tag, "_ov64"}, 64'(out_valid64), 64'd0);
    chk({tag, "_ir64"}, 64'(in_ready64), 64'd1);
    chk({tag, "_imm64"}, out_imm64, 64'd0);
    chk({tag, "_tag64"}, 64'(out_tag64), 64'd0);
    chk({tag, "_ill64"}, 64'(out_ill64), 64'd0);
  endtask

  initial begin
    int c0;
    #17;
    chk_reset_vals("rst");

    // First acceptance on the first edge after reset release.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hFFF00093;
    in_imm_src = 3'b000;
    in_tag = 5'd7;
    rst_n = 1'b1;
    step();
    in_valid = 1'b0;
    chk("i_ov32", 64'(out_valid32), 64'd1);
    chk("i_imm32", 64'(out_imm32), 64'hFFFF_FFFF);
    chk("i_tag32", 64'(out_tag32), 64'd7);
    chk("i_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);

    send(32'hFE000EE3, 3'b010, 5'd1);
    chk("b_imm32", 64'(out_imm32), 64'hFFFF_FFFC);
    chk("b_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    send(32'h800000B7, 3'b100, 5'd2);
    chk("u_imm32", 64'(out_imm32), 64'h8000_0000);
    chk("u_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    send(32'h02300013, 3'b101, 5'd3);
    chk("sh_ill32", 64'(out_ill32), 64'd1);
    chk("sh_imm32", 64'(out_imm32), 64'd3);
    chk("sh_ill64", 64'(out_ill64), 64'd0);
    chk("sh_imm64", out_imm64, 64'd35);
    send(32'hFFFFFFFF, 3'b111, 5'd4);
    chk("rsv_imm32", 64'(out_imm32), 64'd0);
    chk("rsv_ill32", 64'(out_ill32), 64'd1);
    chk("rsv_imm64", out_imm64, 64'd0);
    chk("rsv_ill64", 64'(out_ill64), 64'd1);
    send(32'h000F8073, 3'b110, 5'd5);
    chk("zimm_imm64", out_imm64, 64'd31);
    chk("zimm_imm32", 64'(out_imm32), 64'd31);

    // Continuous out_ready: one acceptance per cycle.
    c0 = cyc;
    for (int i = 0; i < 8; i++) send($urandom, 3'($urandom_range(0, 7)), 5'(i + 8));
    chk("thru_cycles", 64'(cyc - c0), 64'd8);
    step();
    chk("thru_empty", 64'(out_valid32), 64'd0);

    // Backpressure: tags 1,2 accepted, 3 stalled, then released in order.
    out_ready = 1'b0;
    send(32'h00100093, 3'b000, 5'd1);
    chk("bp_ir_after1", 64'(in_ready32), 64'd1);
    send(32'h00200093, 3'b000, 5'd2);
    chk("bp_ir_after2", 64'(in_ready32), 64'd0);
    in_valid = 1'b1;
    in_instr = 32'h00300093;
    in_imm_src = 3'b000;
    in_tag = 5'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_stall_ir", 64'(in_ready32), 64'd0);
      chk("bp_hold_ov", 64'(out_valid32), 64'd1);
      chk("bp_hold_tag", 64'(out_tag32), 64'd1);
      chk("bp_hold_imm", 64'(out_imm32), 64'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_tag2", 64'(out_tag32), 64'd2);
    chk("bp_ir_back", 64'(in_ready32), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_tag3", 64'(out_tag32), 64'd3);
    step();
    chk("bp_done", 64'(out_valid32), 64'd0);

    // Flush with both registers full and an input offered.
    out_ready = 1'b0;
    send(32'h00A00093, 3'b000, 5'd10);
    send(32'h00B00093, 3'b000, 5'd11);
    in_valid = 1'b1;
    in_tag = 5'd12;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_ov32", 64'(out_valid32), 64'd0);
    chk("fl_ir32", 64'(in_ready32), 64'd1);
    chk("fl_ov64", 64'(out_valid64), 64'd0);
    chk("fl_ir64", 64'(in_ready64), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_quiet", 64'(out_valid32), 64'd0);
    end
    // Flush while empty with an acceptable input: the input is dropped.
    in_valid = 1'b1;
    in_tag = 5'd13;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_drop", 64'(out_valid32), 64'd0);

    // Asynchronous reset while stalled with both registers full.
    out_ready = 1'b0;
    send(32'h01400093, 3'b000, 5'd20);
    send(32'h01500093, 3'b000, 5'd21);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("arst_quiet", 64'(out_valid32), 64'd0);

    // Random traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send($urandom, 3'($urandom_range(0, 7)), 5'($urandom));
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("sb32_drained", 64'(q32.size()), 64'd0);
    chk("sb64_drained", 64'(q64.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
